w0rm_bus_memory: RTL and testbench

Word-organised on-chip RAM slave for the W0RM core bus. Sits directly downstream of the core top level. It consumes the core's Address/Data/Read/Write/Valid request outputs and returns read data plus a Valid response into the core's Data_i/Valid_i. Access latency is configurable through wait states, and out-of-range or malformed accesses complete with a fault response so the core never hangs.

---
 rtl/w0rm_bus_memory_if.sv | 28 ++
 rtl/w0rm_bus_memory.sv | 148 ++++++++++++++
 tb/tb_w0rm_bus_memory.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/w0rm_bus_memory_if.sv
// W0RM core bus request/response bundle between the core and a memory slave.
// Latency: none (wires only).
// Backpressure: slave raises Busy_o while it holds a request in wait states.
//
// Signals keep the slave-side names so they line up with the memory's pinout:
//   Address_i/Data_i/Read_i/Write_i/Valid_i : request from the core
//   Data_o/Valid_o/Fault_o/Busy_o           : response and busy back to the core
interface w0rm_bus_memory_if;
    logic [31:0] Address_i;
    logic [31:0] Data_i;
    logic        Read_i;
    logic        Write_i;
    logic        Valid_i;
    logic [31:0] Data_o;
    logic        Valid_o;
    logic        Fault_o;
    logic        Busy_o;

    modport master (
        output Address_i, Data_i, Read_i, Write_i, Valid_i,
        input  Data_o, Valid_o, Fault_o, Busy_o
    );

    modport slave (
        input  Address_i, Data_i, Read_i, Write_i, Valid_i,
        output Data_o, Valid_o, Fault_o, Busy_o
    );
endinterface

// File: rtl/w0rm_bus_memory.sv
// Word-organised RAM slave for the W0RM core bus with fault responses.
// Latency: response one cycle after acceptance plus WAIT_STATES cycles.
// Backpressure: Busy_o high during wait states; requests arriving then are dropped.
//
// Ports:
//   BaseCLK : clock, rising edge
//   Reset   : synchronous, active-high; aborts any transaction in flight
//   bus     : slave modport of w0rm_bus_memory_if (request in, response out)
//
// Optional feature macro: W0RM_BUS_MEM_ALIGN_CHECK_EN
//   defined   -> Address_i[1:0] != 0 is rejected with a fault response
//   undefined -> low address bits are ignored, access hits the containing word
module w0rm_bus_memory #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 0
) (
    input  logic             BaseCLK,
    input  logic             Reset,
    w0rm_bus_memory_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {K_READ, K_WRITE, K_FAULT} kind_t;

    // 33-bit bounds so a region ending at 4 GiB does not wrap.
    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = LO_ADDR + (33'd1 << (ADDR_WIDTH + 2));
    localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [2**ADDR_WIDTH];

    state_t                state;
    logic [3:0]            cnt;
    kind_t                 lat_kind;
    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_dat;

    logic                  in_range;
    logic                  bad_align;
    kind_t                 req_kind;
    logic                  accept;
    logic                  op_now;
    kind_t                 op_kind;
    logic [ADDR_WIDTH-1:0] op_idx;
    logic [31:0]           op_dat;
    logic                  mem_we;
    logic                  addr_lsb_unused;

    assign addr_lsb_unused = ^bus.Address_i[1:0];

    always_comb begin
        in_range = ({1'b0, bus.Address_i} >= LO_ADDR) && ({1'b0, bus.Address_i} < HI_ADDR);
`ifdef W0RM_BUS_MEM_ALIGN_CHECK_EN
        bad_align = (bus.Address_i[1:0] != 2'b00);
`else
        bad_align = 1'b0;
`endif
        if (!in_range || bad_align || (bus.Read_i == bus.Write_i))
            req_kind = K_FAULT;
        else if (bus.Read_i)
            req_kind = K_READ;
        else
            req_kind = K_WRITE;
    end

    assign accept = bus.Valid_i && !bus.Busy_o;

    // The memory operation happens on the edge that enters RESP. With no wait
    // states that is the acceptance edge itself, so the live request is used;
    // otherwise the latched copy is used at the end of the last wait cycle.
    // Committing on entry to RESP means a request accepted during RESP always
    // observes the preceding write without any forwarding path.
    always_comb begin
        if (WAIT_STATES == 0) begin
            op_now  = accept;
            op_kind = req_kind;
            op_idx  = bus.Address_i[ADDR_WIDTH+1:2];
            op_dat  = bus.Data_i;
        end else begin
            op_now  = (state == WAIT) && (cnt == 4'd0);
            op_kind = lat_kind;
            op_idx  = lat_idx;
            op_dat  = lat_dat;
        end
    end

    // Reset suppresses the commit so an aborted write leaves RAM untouched.
    assign mem_we = op_now && (op_kind == K_WRITE) && !Reset;

    always_ff @(posedge BaseCLK) begin
        if (mem_we)
            mem[op_idx] <= op_dat;
    end

    always_ff @(posedge BaseCLK) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_kind    <= K_FAULT;
            lat_idx     <= '0;
            lat_dat     <= 32'd0;
            bus.Data_o  <= 32'd0;
            bus.Valid_o <= 1'b0;
            bus.Fault_o <= 1'b0;
            bus.Busy_o  <= 1'b0;
        end else begin
            bus.Valid_o <= 1'b0;
            bus.Fault_o <= 1'b0;

            case (state)
                IDLE, RESP: begin
                    state <= IDLE;
                    if (accept) begin
                        lat_kind <= req_kind;
                        lat_idx  <= bus.Address_i[ADDR_WIDTH+1:2];
                        lat_dat  <= bus.Data_i;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state      <= WAIT;
                            cnt        <= WS_LOAD;
                            bus.Busy_o <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        bus.Busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Response registers load on the edge entering RESP; Data_o holds
            // its value otherwise.
            if (op_now) begin
                bus.Valid_o <= 1'b1;
                bus.Fault_o <= (op_kind == K_FAULT);
                bus.Data_o  <= (op_kind == K_READ) ? mem[op_idx] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_w0rm_bus_memory.sv
// Scoreboard bench for w0rm_bus_memory: one instance with no wait states and
// one with three, driven by directed sequences and random traffic. A word-array
// reference model predicts every response and its arrival cycle.
module tb_w0rm_bus_memory;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    always #5 clk = ~clk;

    w0rm_bus_memory_if bus0 ();
    w0rm_bus_memory_if bus3 ();

    w0rm_bus_memory #(.BASE_ADDR(32'h0), .ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .BaseCLK(clk), .Reset(rst0), .bus(bus0.slave)
    );
    w0rm_bus_memory #(.BASE_ADDR(32'h0), .ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .BaseCLK(clk), .Reset(rst3), .bus(bus3.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc [2];
    logic [31:0] mdl [2][1024];
    exp_t q0 [$];
    exp_t q1 [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One bus cycle on instance s (0 = no wait states, 1 = three wait states).
    // The other bus is forced idle. The expected busy level and acceptance are
    // derived from the bench's own record of the last accepted request.
    task automatic step(input int s, input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic r, input logic w, input bit no_exp);
        int   ws;
        bit   busy_exp;
        logic busy_act;
        bit   fault;
        int   idx;
        exp_t e;
        @(negedge clk);
        ws = (s == 0) ? 0 : 3;
        busy_exp = (cyc >= last_acc[s] + 1) && (cyc <= last_acc[s] + ws);
        if (s == 0) begin
            bus0.Valid_i = v; bus0.Address_i = a; bus0.Data_i = d;
            bus0.Read_i = r; bus0.Write_i = w;
            bus3.Valid_i = 1'b0;
            busy_act = bus0.Busy_o;
        end else begin
            bus3.Valid_i = v; bus3.Address_i = a; bus3.Data_i = d;
            bus3.Read_i = r; bus3.Write_i = w;
            bus0.Valid_i = 1'b0;
            busy_act = bus3.Busy_o;
        end
        chk(s == 0 ? "busy_ws0" : "busy_ws3", {31'd0, busy_act}, {31'd0, busy_exp});
        if (v && !busy_exp) begin
            last_acc[s] = cyc;
            if (!no_exp) begin
                fault = (a >= 32'h0000_1000) || (r == w);
`ifdef W0RM_BUS_MEM_ALIGN_CHECK_EN
                if (a[1:0] != 2'b00) fault = 1'b1;
`endif
                idx = int'(a[11:2]);
                e.fault = fault;
                e.cyc   = cyc + 1 + ws;
                if (fault)      e.data = 32'd0;
                else if (r)     e.data = mdl[s][idx];
                else begin
                    e.data = 32'd0;
                    mdl[s][idx] = d;
                end
                if (s == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic idle(input int s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitors: every Valid_o pulse must match the oldest outstanding
    // expectation in data, fault and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.Valid_o) begin
            if (q0.size() == 0) begin
                chk("ws0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                chk("ws0_data", bus0.Data_o, e.data);
                chk("ws0_fault", {31'd0, bus0.Fault_o}, {31'd0, e.fault});
                chk("ws0_cycle", cyc, e.cyc);
            end
        end else begin
            chk("ws0_idle_fault", {31'd0, bus0.Fault_o}, 32'd0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus3.Valid_o) begin
            if (q1.size() == 0) begin
                chk("ws3_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("ws3_data", bus3.Data_o, e.data);
                chk("ws3_fault", {31'd0, bus3.Fault_o}, {31'd0, e.fault});
                chk("ws3_cycle", cyc, e.cyc);
            end
        end else begin
            chk("ws3_idle_fault", {31'd0, bus3.Fault_o}, 32'd0);
        end
    end

    initial begin
        last_acc[0] = -100;
        last_acc[1] = -100;
        rst0 = 1'b1; rst3 = 1'b1;
        bus0.Valid_i = 1'b0; bus0.Address_i = 32'd0; bus0.Data_i = 32'd0;
        bus0.Read_i = 1'b0; bus0.Write_i = 1'b0;
        bus3.Valid_i = 1'b0; bus3.Address_i = 32'd0; bus3.Data_i = 32'd0;
        bus3.Read_i = 1'b0; bus3.Write_i = 1'b0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;

        // Reset values.
        chk("rst_data0",  bus0.Data_o, 32'd0);
        chk("rst_valid0", {31'd0, bus0.Valid_o}, 32'd0);
        chk("rst_busy0",  {31'd0, bus0.Busy_o}, 32'd0);
        chk("rst_data3",  bus3.Data_o, 32'd0);
        chk("rst_valid3", {31'd0, bus3.Valid_o}, 32'd0);
        chk("rst_busy3",  {31'd0, bus3.Busy_o}, 32'd0);

        // Give the first 64 words of each RAM known contents.
        for (int i = 0; i < 64; i++)
            step(0, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(1, 1'b1, 32'(i * 4), $urandom, 1'b0, 1'b1, 1'b0);
            idle(1, 3);
        end

        // Write then read the same word back to back.
        step(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        step(0, 1'b1, 32'h10, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(0, 2);

        // Streaming bursts of 8 writes then 8 reads.
        for (int i = 0; i < 8; i++)
            step(0, 1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            step(0, 1'b1, 32'(i * 4), 32'd0, 1'b1, 1'b0, 1'b0);
        idle(0, 2);

        // Faults: one word past the region, both and neither qualifier, then readback.
        step(0, 1'b1, 32'h1000, 32'd0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 32'h10, 32'h5555_5555, 1'b1, 1'b1, 1'b0);
        step(0, 1'b1, 32'h10, 32'h6666_6666, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 32'h10, 32'd0, 1'b1, 1'b0, 1'b0);
        // Misaligned read: fault with the alignment check, else the containing word.
        step(0, 1'b1, 32'h12, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(0, 2);

        // Wait states: request dropped while busy; new request accepted in RESP.
        step(1, 1'b1, 32'h0, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1, 1'b1, 32'h4, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1, 1'b1, 32'h8, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(1, 5);

        // Reset during the second wait cycle aborts a write.
        step(1, 1'b1, 32'h20, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0);
        idle(1, 4);
        step(1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
        idle(1, 2);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        last_acc[1] = -100;
        chk("abort_valid3", {31'd0, bus3.Valid_o}, 32'd0);
        chk("abort_busy3",  {31'd0, bus3.Busy_o}, 32'd0);
        chk("abort_data3",  bus3.Data_o, 32'd0);
        step(1, 1'b1, 32'h20, 32'd0, 1'b1, 1'b0, 1'b0);
        idle(1, 6);

        // Random traffic on both instances.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 150; n++) begin
                logic [31:0] a;
                int sel;
                sel = $urandom_range(0, 9);
                if (sel == 0)      a = 32'h1000 + 32'($urandom_range(0, 255) << 2);
                else if (sel == 1) a = $urandom | 32'h0000_1000;
                else               a = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3));
                step(s, ($urandom_range(0, 3) != 0), a, $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
            idle(s, 6);
        end

        idle(0, 4);
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q1", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
